pll_reset_seq: RTL and testbench
================================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter AREST_CYC, default 16, cycles pll_areset is held high per PLL reset attempt.
REQ-002 Parameter STABLE_CYC, default 1024, consecutive synchronised-locked cycles required before release.
REQ-003 Parameter TIMEOUT_CYC, default 65536, cycles allowed in WAIT before a retry.
REQ-004 Parameter GAP_CYC, default 64, cycles between successive domain reset releases.
REQ-005 clk  input  1  system clock, 50 MHz board oscillator; one clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 pll_locked  input  1  PLL lock flag, asynchronous to clk.
REQ-008 pll_areset  output  1  PLL reset, active high.
REQ-009 sys_rst_n  output  1  core domain reset, active low, released first.
REQ-010 ddr_rst_n  output  1  memory controller reset, active low, released second.
REQ-011 vid_rst_n  output  1  display domain reset, active low, released third.
REQ-012 ready  output  1  high only in RUN.
REQ-013 retry_cnt  output  8  count of WAIT timeouts, saturating at 255.
REQ-014 loss_cnt  output  8  count of lock losses from RUN, saturating at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchroniser; lk denotes its output, 2 cycles behind pll_locked.
REQ-016 FSM states SHALL be PLLRST, WAIT, STABLE, REL_SYS, REL_DDR, REL_VID, RUN, driven by one shared down-counter cnt sized for the largest parameter.
REQ-017 PLLRST: pll_areset=1; cnt loads AREST_CYC-1 on entry; at cnt==0 go to WAIT.
REQ-018 WAIT: pll_areset=0; cnt loads TIMEOUT_CYC-1 on entry; lk=1 goes to STABLE; cnt==0 with lk=0 goes to PLLRST and increments retry_cnt.
REQ-019 When lk=1 and cnt==0 occur in the same WAIT cycle, lk SHALL win and the FSM goes to STABLE with no retry.
REQ-020 STABLE: cnt loads STABLE_CYC-1 on entry; lk=0 goes to WAIT with a fresh timeout; cnt==0 with lk=1 goes to REL_SYS.
REQ-021 REL_SYS: sys_rst_n=1 from the first cycle in the state; after GAP_CYC cycles go to REL_DDR.
REQ-022 REL_DDR: ddr_rst_n=1 additionally; after GAP_CYC cycles go to REL_VID.
REQ-023 REL_VID: vid_rst_n=1 additionally; after GAP_CYC cycles go to RUN.
REQ-024 RUN: ready=1; all three resets deasserted; stays until lk=0.
REQ-025 lk=0 in any of REL_SYS, REL_DDR, REL_VID or RUN SHALL, on the next edge, drive sys_rst_n, ddr_rst_n, vid_rst_n and ready to 0 and enter PLLRST.
REQ-026 Each such lock loss SHALL increment loss_cnt.
REQ-027 All outputs SHALL be registered and decoded from the next state, so each changes on the same edge as the state transition.
REQ-028 Resets SHALL never release out of order, and a domain reset SHALL never deassert while pll_areset=1.
REQ-029 Counters SHALL saturate at 255 and never wrap.

Reset
REQ-030 rst_n=0 sampled on an edge SHALL force PLLRST with cnt=AREST_CYC-1, pll_areset=1, all *_rst_n=0, ready=0, retry_cnt=0, loss_cnt=0 and synchroniser flops=0, regardless of state.
REQ-031 rst_n asserted mid-sequence, including RUN, SHALL behave identically to power-on reset.

Structure
REQ-032 A shared package SHALL hold the state enumeration and the default parameter constants.
REQ-033 The synchroniser SHALL be a separate sub-module, sync_2ff, with ports clk, rst_n, d, q.

Verification (bench overrides: AREST_CYC=4, STABLE_CYC=8, TIMEOUT_CYC=32, GAP_CYC=2)
REQ-034 Nominal: rst_n high at edge 0, pll_locked high from cycle 10 -> pll_areset high for 4 cycles; sys_rst_n rises 8 cycles after lk first high; ddr_rst_n 2 cycles later; vid_rst_n 2 cycles after that; ready 2 cycles after vid_rst_n.
REQ-035 Timeout: pll_locked held low -> pll_areset re-pulses every 36 cycles; retry_cnt increments once per pulse; saturates at 255 after 255 timeouts.
REQ-036 Glitch in STABLE: pll_locked low for 1 cycle at STABLE count 5 -> FSM returns to WAIT and the full 8-cycle STABLE restarts; no reset released early.
REQ-037 Loss in RUN: pll_locked falls -> 2 cycles later all resets and ready drop on one edge; loss_cnt=1; pll_areset high for 4 cycles; sequence repeats.
REQ-038 Mid-release reset: rst_n=0 during REL_DDR -> next edge gives pll_areset=1, all rst_n=0, both counters 0.
REQ-039 Simultaneous events: lk rises on the WAIT cycle where cnt==0 -> STABLE entered; retry_cnt unchanged.

Source files
------------

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and default timing constants for the PLL bring-up / reset release sequencer.
package pll_reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_PLLRST  = 3'd0,
      ST_WAIT    = 3'd1,
      ST_STABLE  = 3'd2,
      ST_REL_SYS = 3'd3,
      ST_REL_DDR = 3'd4,
      ST_REL_VID = 3'd5,
      ST_RUN     = 3'd6
   } state_e;

   localparam int DEF_AREST_CYC   = 16;
   localparam int DEF_STABLE_CYC  = 1024;
   localparam int DEF_TIMEOUT_CYC = 65536;
   localparam int DEF_GAP_CYC     = 64;

   // Width of a down-counter that must hold (largest period - 1).
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff
   import pll_reset_seq_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset / lock qualification sequencer; releases sys, ddr and vid resets in order
// once lock has been stable, and restarts the whole sequence on any lock loss.
module pll_reset_seq
   import pll_reset_seq_pkg::*;
#(
   parameter int AREST_CYC   = DEF_AREST_CYC,
   parameter int STABLE_CYC  = DEF_STABLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       pll_areset,
   output logic       sys_rst_n,
   output logic       ddr_rst_n,
   output logic       vid_rst_n,
   output logic       ready,
   output logic [7:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   localparam int CNT_W = cnt_width(AREST_CYC, STABLE_CYC, TIMEOUT_CYC, GAP_CYC);

   localparam logic [CNT_W-1:0] AREST_LD   = CNT_W'(AREST_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LD  = CNT_W'(STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYC - 1);

   logic lk;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lk)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       retry_q, retry_d;
   logic [7:0]       loss_q, loss_d;
   logic             pll_areset_q, pll_areset_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             ddr_rst_n_q, ddr_rst_n_d;
   logic             vid_rst_n_q, vid_rst_n_d;
   logic             ready_q, ready_d;
   logic             cnt_zero;

   function automatic logic [CNT_W-1:0] entry_cnt(input state_e s);
      case (s)
         ST_PLLRST:                          return AREST_LD;
         ST_WAIT:                            return TIMEOUT_LD;
         ST_STABLE:                          return STABLE_LD;
         ST_REL_SYS, ST_REL_DDR, ST_REL_VID: return GAP_LD;
         default:                            return '0;
      endcase
   endfunction

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      loss_d  = loss_q;

      // Lock always beats the timeout; lock loss beats the gap counter.
      case (state_q)
         ST_PLLRST: if (cnt_zero) state_d = ST_WAIT;
         ST_WAIT: begin
            if (lk) state_d = ST_STABLE;
            else if (cnt_zero) begin
               state_d = ST_PLLRST;
               if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
            end
         end
         ST_STABLE: begin
            if (!lk) state_d = ST_WAIT;
            else if (cnt_zero) state_d = ST_REL_SYS;
         end
         ST_REL_SYS, ST_REL_DDR, ST_REL_VID, ST_RUN: begin
            if (!lk) begin
               state_d = ST_PLLRST;
               if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            end else if (cnt_zero) begin
               case (state_q)
                  ST_REL_SYS: state_d = ST_REL_DDR;
                  ST_REL_DDR: state_d = ST_REL_VID;
                  ST_REL_VID: state_d = ST_RUN;
                  default:    state_d = ST_RUN;
               endcase
            end
         end
         default: state_d = ST_PLLRST;
      endcase

      if (state_d != state_q) cnt_d = entry_cnt(state_d);
      else if (!cnt_zero)     cnt_d = cnt_q - CNT_W'(1);
      else                    cnt_d = cnt_q;

      pll_areset_d = (state_d == ST_PLLRST);
      sys_rst_n_d  = (state_d inside {ST_REL_SYS, ST_REL_DDR, ST_REL_VID, ST_RUN});
      ddr_rst_n_d  = (state_d inside {ST_REL_DDR, ST_REL_VID, ST_RUN});
      vid_rst_n_d  = (state_d inside {ST_REL_VID, ST_RUN});
      ready_d      = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_PLLRST;
         cnt_q        <= AREST_LD;
         retry_q      <= 8'd0;
         loss_q       <= 8'd0;
         pll_areset_q <= 1'b1;
         sys_rst_n_q  <= 1'b0;
         ddr_rst_n_q  <= 1'b0;
         vid_rst_n_q  <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         loss_q       <= loss_d;
         pll_areset_q <= pll_areset_d;
         sys_rst_n_q  <= sys_rst_n_d;
         ddr_rst_n_q  <= ddr_rst_n_d;
         vid_rst_n_q  <= vid_rst_n_d;
         ready_q      <= ready_d;
      end
   end

   assign pll_areset = pll_areset_q;
   assign sys_rst_n  = sys_rst_n_q;
   assign ddr_rst_n  = ddr_rst_n_q;
   assign vid_rst_n  = vid_rst_n_q;
   assign ready      = ready_q;
   assign retry_cnt  = retry_q;
   assign loss_cnt   = loss_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench: stimulus schedules expected output vectors by cycle; the monitor
// compares at each scheduled cycle and flags any output change that was not scheduled.
module tb_pll_reset_seq;

   typedef struct packed {
      logic       areset;
      logic       sys;
      logic       ddr;
      logic       vid;
      logic       rdy;
      logic [7:0] retry;
      logic [7:0] loss;
   } obs_t;

   typedef struct {
      int    cyc;
      obs_t  o;
      string nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_areset, sys_rst_n, ddr_rst_n, vid_rst_n, ready;
   logic [7:0] retry_cnt, loss_cnt;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];
   obs_t cur, prev;

   pll_reset_seq #(
      .AREST_CYC   (4),
      .STABLE_CYC  (8),
      .TIMEOUT_CYC (32),
      .GAP_CYC     (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .pll_areset (pll_areset),
      .sys_rst_n  (sys_rst_n),
      .ddr_rst_n  (ddr_rst_n),
      .vid_rst_n  (vid_rst_n),
      .ready      (ready),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic obs_t mk(input bit a, input bit s, input bit d, input bit v,
                               input bit r, input int rt, input int ls);
      obs_t o;
      o.areset = a; o.sys = s; o.ddr = d; o.vid = v; o.rdy = r;
      o.retry = 8'(rt); o.loss = 8'(ls);
      return o;
   endfunction

   task automatic push(input int at, input obs_t o, input string nm);
      exp_t e;
      e.cyc = at; e.o = o; e.nm = nm;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic phase_start(output int c);
      mon_en     = 1'b0;
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      c      = cyc;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      push(c + 1, mk(1,0,0,0,0,0,0), "reset_state");
      push(c + 4, mk(0,0,0,0,0,0,0), "areset_fall");
   endtask

   // Monitor: outputs are sampled on the falling edge, well away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      cur = {pll_areset, sys_rst_n, ddr_rst_n, vid_rst_n, ready, retry_cnt, loss_cnt};
      if (mon_en) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL %s missed: scheduled cyc %0d now %0d", e.nm, e.cyc, cyc);
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (cur !== e.o) begin
               errors++;
               $display("FAIL %s cyc %0d got %h exp %h", e.nm, cyc, cur, e.o);
            end
         end else if (cur !== prev) begin
            checks++; errors++;
            $display("FAIL unexpected_change cyc %0d got %h was %h", cyc, cur, prev);
         end
      end
      prev = cur;
   end

   initial begin
      int c;

      // Nominal bring-up, glitch in STABLE, loss in RUN, reset during REL_DDR.
      phase_start(c);
      wait_until(c + 10); pll_locked = 1'b1;
      push(c + 21, mk(0,1,0,0,0,0,0), "sys_rel");
      push(c + 23, mk(0,1,1,0,0,0,0), "ddr_rel");
      push(c + 25, mk(0,1,1,1,0,0,0), "vid_rel");
      push(c + 27, mk(0,1,1,1,1,0,0), "run");
      wait_until(c + 30); pll_locked = 1'b0;
      push(c + 33, mk(1,0,0,0,0,0,1), "loss_run");
      push(c + 37, mk(0,0,0,0,0,0,1), "areset_fall2");
      wait_until(c + 40); pll_locked = 1'b1;
      wait_until(c + 43); pll_locked = 1'b0;
      wait_until(c + 44); pll_locked = 1'b1;
      push(c + 55, mk(0,1,0,0,0,0,1), "sys_rel_glitch");
      push(c + 57, mk(0,1,1,0,0,0,1), "ddr_rel_glitch");
      push(c + 59, mk(0,1,1,1,0,0,1), "vid_rel_glitch");
      push(c + 61, mk(0,1,1,1,1,0,1), "run_glitch");
      wait_until(c + 70); pll_locked = 1'b0;
      push(c + 73, mk(1,0,0,0,0,0,2), "loss_run2");
      push(c + 77, mk(0,0,0,0,0,0,2), "areset_fall3");
      wait_until(c + 80); pll_locked = 1'b1;
      push(c + 91, mk(0,1,0,0,0,0,2), "sys_rel3");
      push(c + 93, mk(0,1,1,0,0,0,2), "ddr_rel3");
      wait_until(c + 93); rst_n = 1'b0;
      push(c + 94, mk(1,0,0,0,0,0,0), "mid_release_rst");
      wait_until(c + 97);

      // Lock arrives on the exact WAIT timeout cycle; then reset from RUN.
      phase_start(c);
      wait_until(c + 33); pll_locked = 1'b1;
      push(c + 44, mk(0,1,0,0,0,0,0), "sys_rel_simul");
      push(c + 46, mk(0,1,1,0,0,0,0), "ddr_rel_simul");
      push(c + 48, mk(0,1,1,1,0,0,0), "vid_rel_simul");
      push(c + 50, mk(0,1,1,1,1,0,0), "run_simul");
      wait_until(c + 55); rst_n = 1'b0;
      push(c + 56, mk(1,0,0,0,0,0,0), "run_rst");
      wait_until(c + 59);

      // Lock never arrives: periodic retries, retry_cnt saturates at 255.
      phase_start(c);
      for (int k = 1; k <= 257; k++) begin
         push(c + 36*k,     mk(1,0,0,0,0,(k > 255) ? 255 : k,0), "retry_pulse");
         push(c + 36*k + 4, mk(0,0,0,0,0,(k > 255) ? 255 : k,0), "retry_fall");
      end
      wait_until(c + 36*257 + 8);

      mon_en = 1'b0;
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++; errors++;
         $display("FAIL %s never checked: scheduled cyc %0d", e.nm, e.cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
